// File: rtl/row_win_pkg.sv
// Shared types and constants for the row-window controller: FSM encoding,
// window descriptor layout and the configuration legality rule.
package row_win_pkg;

   localparam int unsigned DEPTH_DEFAULT = 16;
   localparam int unsigned DESC_W        = 8;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_CALC  = 3'd1,
      ST_FILL  = 3'd2,
      ST_ISSUE = 3'd3,
      ST_WAIT  = 3'd4,
      ST_DRAIN = 3'd5
   } state_e;

   // Fields are sized for the widest supported buffer; users take the low PTR_W bits.
   typedef struct packed {
      logic [DESC_W-1:0] start_addr;
      logic [DESC_W-1:0] end_addr;
   } win_desc_t;

   function automatic logic cfg_legal(input int unsigned win,
                                      input int unsigned stride,
                                      input int unsigned rows,
                                      input int unsigned depth);
      return (win >= 1) && (win <= depth) && (stride >= 1) &&
             (stride <= win) && (rows >= win);
   endfunction

endpackage

// File: rtl/row_window_ctrl_if.sv
// Job control, producer, engine and status signals of the row-window controller.
interface row_window_ctrl_if #(
   parameter int unsigned PTR_W  = 4,
   parameter int unsigned CNT_W  = 5,
   parameter int unsigned ROWS_W = 10
);
   logic              start;
   logic [CNT_W-1:0]  cfg_win_rows;
   logic [CNT_W-1:0]  cfg_stride;
   logic [ROWS_W-1:0] cfg_num_rows;
   logic              in_valid;
   logic              in_ready;
   logic              wr_en;
   logic [PTR_W-1:0]  wr_addr;
   logic              win_valid;
   logic              win_ready;
   logic [PTR_W-1:0]  win_start_addr;
   logic [PTR_W-1:0]  win_end_addr;
   logic              win_done;
   logic [CNT_W-1:0]  occupancy;
   logic              busy;
   logic              done;
   logic              cfg_err;

   modport master (
      output start, cfg_win_rows, cfg_stride, cfg_num_rows,
      output in_valid, win_ready, win_done,
      input  in_ready, wr_en, wr_addr, win_valid, win_start_addr, win_end_addr,
      input  occupancy, busy, done, cfg_err
   );

   modport slave (
      input  start, cfg_win_rows, cfg_stride, cfg_num_rows,
      input  in_valid, win_ready, win_done,
      output in_ready, wr_en, wr_addr, win_valid, win_start_addr, win_end_addr,
      output occupancy, busy, done, cfg_err
   );
endinterface

// File: rtl/row_occupancy_counter.sv
// Row-buffer occupancy: +1 per write, -amount per release, both may coincide.
module row_occupancy_counter #(
   parameter int unsigned CNT_W = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr_i,
   input  logic             inc_i,
   input  logic             dec_i,
   input  logic [CNT_W-1:0] dec_amt_i,
   output logic [CNT_W-1:0] occ_o
);
   logic [CNT_W-1:0] occ_q, occ_d;

   always_comb begin
      occ_d = occ_q + CNT_W'(inc_i) - (dec_i ? dec_amt_i : '0);
      if (clr_i) occ_d = '0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) occ_q <= '0;
      else     occ_q <= occ_d;
   end

   assign occ_o = occ_q;
endmodule

// File: rtl/row_window_ctrl.sv
// Circular row-buffer controller: write addressing, occupancy tracking and
// window descriptor sequencing for a sliding-window engine, one job per start.
module row_window_ctrl
   import row_win_pkg::*;
#(
   parameter int unsigned DEPTH  = DEPTH_DEFAULT,
   parameter int unsigned PTR_W  = 4,
   parameter int unsigned CNT_W  = 5,
   parameter int unsigned ROWS_W = 10
) (
   input logic               clk,
   input logic               rst,
   row_window_ctrl_if.slave  bus
);
   localparam logic [2:0] IDLE  = ST_IDLE;
   localparam logic [2:0] CALC  = ST_CALC;
   localparam logic [2:0] FILL  = ST_FILL;
   localparam logic [2:0] ISSUE = ST_ISSUE;
   localparam logic [2:0] WAIT  = ST_WAIT;
   localparam logic [2:0] DRAIN = ST_DRAIN;

   logic [2:0]        state_q, state_d;
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [ROWS_W-1:0] rows_in_q, rows_in_d;
   logic [CNT_W-1:0]  win_q, win_d, stride_q, stride_d;
   logic [ROWS_W-1:0] num_q, num_d;
   logic [ROWS_W-1:0] wl_q, wl_d, rem_q, rem_d;
   logic              done_q, done_d, cfg_err_q, cfg_err_d;

   logic [CNT_W-1:0]  occ;
   logic              busy_w, in_ready_w, wr_fire, rel_fire, drain_exit, cfg_ok;
   win_desc_t         desc;
   logic              desc_unused;

   assign busy_w     = (state_q != IDLE);
   assign in_ready_w = busy_w && (32'(occ) < DEPTH) && (rows_in_q < num_q);
   assign wr_fire    = bus.in_valid && in_ready_w;
   assign rel_fire   = (state_q == WAIT) && bus.win_done;
   assign drain_exit = (state_q == DRAIN) && (rows_in_q == num_q);
   assign cfg_ok     = cfg_legal(32'(bus.cfg_win_rows), 32'(bus.cfg_stride),
                                 32'(bus.cfg_num_rows), DEPTH);

   row_occupancy_counter #(.CNT_W(CNT_W)) u_occ (
      .clk       (clk),
      .rst       (rst),
      .clr_i     (drain_exit),
      .inc_i     (wr_fire),
      .dec_i     (rel_fire),
      .dec_amt_i (stride_q),
      .occ_o     (occ)
   );

   always_comb begin
      state_d   = state_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      rows_in_d = rows_in_q;
      win_d     = win_q;
      stride_d  = stride_q;
      num_d     = num_q;
      wl_d      = wl_q;
      rem_d     = rem_q;
      done_d    = 1'b0;
      cfg_err_d = 1'b0;

      if (wr_fire) begin
         wr_ptr_d  = wr_ptr_q + PTR_W'(1);
         rows_in_d = rows_in_q + ROWS_W'(1);
      end
      if (rel_fire) rd_ptr_d = rd_ptr_q + PTR_W'(stride_q);

      case (state_q)
         IDLE: begin
            if (bus.start) begin
               if (cfg_ok) begin
                  state_d  = CALC;
                  win_d    = bus.cfg_win_rows;
                  stride_d = bus.cfg_stride;
                  num_d    = bus.cfg_num_rows;
                  rem_d    = bus.cfg_num_rows - ROWS_W'(bus.cfg_win_rows);
                  wl_d     = ROWS_W'(1);
               end else begin
                  cfg_err_d = 1'b1;
               end
            end
         end
         // windows_left = (num - win)/stride + 1 by repeated subtraction
         CALC: begin
            if (rem_q >= ROWS_W'(stride_q)) begin
               rem_d = rem_q - ROWS_W'(stride_q);
               wl_d  = wl_q + ROWS_W'(1);
            end else begin
               state_d = FILL;
            end
         end
         FILL:  if (occ >= win_q) state_d = ISSUE;
         ISSUE: if (bus.win_ready) state_d = WAIT;
         WAIT: begin
            if (bus.win_done) begin
               wl_d    = wl_q - ROWS_W'(1);
               state_d = (wl_q == ROWS_W'(1)) ? DRAIN : FILL;
            end
         end
         DRAIN: begin
            if (drain_exit) begin
               state_d   = IDLE;
               done_d    = 1'b1;
               wr_ptr_d  = '0;
               rd_ptr_d  = '0;
               rows_in_d = '0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         rows_in_q <= '0;
         win_q     <= '0;
         stride_q  <= '0;
         num_q     <= '0;
         wl_q      <= '0;
         rem_q     <= '0;
         done_q    <= 1'b0;
         cfg_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         rows_in_q <= rows_in_d;
         win_q     <= win_d;
         stride_q  <= stride_d;
         num_q     <= num_d;
         wl_q      <= wl_d;
         rem_q     <= rem_d;
         done_q    <= done_d;
         cfg_err_q <= cfg_err_d;
      end
   end

   always_comb begin
      desc = '0;
      desc.start_addr[PTR_W-1:0] = rd_ptr_q;
      desc.end_addr[PTR_W-1:0]   = rd_ptr_q + PTR_W'(win_q - CNT_W'(1));
   end
   assign desc_unused = ^desc;

   assign bus.in_ready       = in_ready_w;
   assign bus.wr_en          = wr_fire;
   assign bus.wr_addr        = wr_ptr_q;
   assign bus.win_valid      = (state_q == ISSUE);
   // Gated so the addresses read zero outside a descriptor (incl. after reset)
   assign bus.win_start_addr = (state_q == ISSUE) ? desc.start_addr[PTR_W-1:0] : '0;
   assign bus.win_end_addr   = (state_q == ISSUE) ? desc.end_addr[PTR_W-1:0] : '0;
   assign bus.occupancy      = occ;
   assign bus.busy           = busy_w;
   assign bus.done           = done_q;
   assign bus.cfg_err        = cfg_err_q;
endmodule

// File: tb/tb_row_window_ctrl.sv
// Directed bench for row_window_ctrl with an 8-slot buffer.
module tb_row_window_ctrl;
   localparam int unsigned DEPTH  = 8;
   localparam int unsigned PTR_W  = 3;
   localparam int unsigned CNT_W  = 4;
   localparam int unsigned ROWS_W = 10;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   row_window_ctrl_if #(.PTR_W(PTR_W), .CNT_W(CNT_W), .ROWS_W(ROWS_W)) bus ();

   row_window_ctrl #(.DEPTH(DEPTH), .PTR_W(PTR_W), .CNT_W(CNT_W), .ROWS_W(ROWS_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_vec = 0;
   int n_err = 0;

   int got_s [16];
   int got_e [16];
   int wr_log [32];
   int ndesc, nwr, max_occ, full_ready_bad, ndone, done_cyc, last_wr_cyc, dcnt, dones_sent;
   bit saw_full, busy_last;
   int wcnt;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_desc(input string tag, input int i, input int s, input int e);
      check($sformatf("%s.desc%0d.start", tag, i), 32'(got_s[i]), 32'(s));
      check($sformatf("%s.desc%0d.end", tag, i), 32'(got_e[i]), 32'(e));
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, ".in_ready"}, 32'(bus.in_ready), 32'd0);
      check({tag, ".wr_en"}, 32'(bus.wr_en), 32'd0);
      check({tag, ".wr_addr"}, 32'(bus.wr_addr), 32'd0);
      check({tag, ".win_valid"}, 32'(bus.win_valid), 32'd0);
      check({tag, ".win_start"}, 32'(bus.win_start_addr), 32'd0);
      check({tag, ".win_end"}, 32'(bus.win_end_addr), 32'd0);
      check({tag, ".occupancy"}, 32'(bus.occupancy), 32'd0);
      check({tag, ".busy"}, 32'(bus.busy), 32'd0);
      check({tag, ".done"}, 32'(bus.done), 32'd0);
      check({tag, ".cfg_err"}, 32'(bus.cfg_err), 32'd0);
   endtask

   task automatic clear_log();
      ndesc = 0; nwr = 0; max_occ = 0; saw_full = 0; full_ready_bad = 0;
      ndone = 0; done_cyc = -1; last_wr_cyc = -1; busy_last = 0; dcnt = 0; dones_sent = 0;
   endtask

   task automatic start_job(input int w, input int s, input int n);
      @(negedge clk);
      bus.in_valid     = 1'b0;
      bus.start        = 1'b1;
      bus.cfg_win_rows = CNT_W'(w);
      bus.cfg_stride   = CNT_W'(s);
      bus.cfg_num_rows = ROWS_W'(n);
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   // Producer always valid (optionally holding the last row until nwin windows finish),
   // engine always ready, win_done two cycles after each accepted descriptor.
   task automatic run_job(input int budget, input bit hold_last, input int nrows, input int nwin);
      for (int k = 0; k < budget; k++) begin
         @(negedge clk);
         if (bus.win_done) dones_sent++;
         bus.win_ready = 1'b1;
         bus.win_done  = (dcnt == 1);
         if (dcnt > 0) dcnt--;
         bus.in_valid = !(hold_last && (nwr == nrows - 1) && (dones_sent < nwin));
         #1;
         if (bus.wr_en) begin
            if (nwr < 32) wr_log[nwr] = int'(bus.wr_addr);
            nwr++;
            last_wr_cyc = k;
            busy_last   = bus.busy;
         end
         if (int'(bus.occupancy) > max_occ) max_occ = int'(bus.occupancy);
         if (int'(bus.occupancy) == DEPTH) begin
            saw_full = 1'b1;
            if (bus.in_ready) full_ready_bad++;
         end
         if (bus.win_valid && bus.win_ready) begin
            if (ndesc < 16) begin
               got_s[ndesc] = int'(bus.win_start_addr);
               got_e[ndesc] = int'(bus.win_end_addr);
            end
            ndesc++;
            dcnt = 2;
         end
         if (bus.done) begin
            ndone++;
            done_cyc = k;
            break;
         end
      end
      bus.in_valid = 1'b0;
      bus.win_done = 1'b0;
   endtask

   initial begin
      bus.start = 1'b0; bus.cfg_win_rows = '0; bus.cfg_stride = '0; bus.cfg_num_rows = '0;
      bus.in_valid = 1'b0; bus.win_ready = 1'b0; bus.win_done = 1'b0;
      rst = 1'b1;
      #2;
      check_outputs_zero("reset");
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      // Illegal: win = 0
      @(negedge clk);
      bus.start = 1'b1; bus.cfg_win_rows = CNT_W'(0); bus.cfg_stride = CNT_W'(1); bus.cfg_num_rows = ROWS_W'(5);
      @(negedge clk);
      bus.start = 1'b0;
      #1;
      check("ill_win0.cfg_err", 32'(bus.cfg_err), 32'd1);
      check("ill_win0.busy", 32'(bus.busy), 32'd0);
      @(negedge clk); #1;
      check("ill_win0.cfg_err_clear", 32'(bus.cfg_err), 32'd0);
      check("ill_win0.busy_after", 32'(bus.busy), 32'd0);

      // Illegal: stride > win
      @(negedge clk);
      bus.start = 1'b1; bus.cfg_win_rows = CNT_W'(3); bus.cfg_stride = CNT_W'(4); bus.cfg_num_rows = ROWS_W'(5);
      @(negedge clk);
      bus.start = 1'b0;
      #1;
      check("ill_stride.cfg_err", 32'(bus.cfg_err), 32'd1);
      check("ill_stride.busy", 32'(bus.busy), 32'd0);
      @(negedge clk); #1;
      check("ill_stride.cfg_err_clear", 32'(bus.cfg_err), 32'd0);

      // Job 1: win=3 stride=1 rows=5 -> (0,2) (1,3) (2,4)
      clear_log();
      start_job(3, 1, 5);
      run_job(300, 1'b0, 5, 3);
      check("job1.ndesc", 32'(ndesc), 32'd3);
      check_desc("job1", 0, 0, 2);
      check_desc("job1", 1, 1, 3);
      check_desc("job1", 2, 2, 4);
      check("job1.maxocc_le5", 32'(max_occ <= 5), 32'd1);
      check("job1.nwr", 32'(nwr), 32'd5);
      check("job1.done", 32'(ndone), 32'd1);
      check("job1.occ_at_done", 32'(bus.occupancy), 32'd0);
      @(negedge clk); #1;
      check("job1.done_one_pulse", 32'(bus.done), 32'd0);
      check("job1.busy_after", 32'(bus.busy), 32'd0);
      check("job1.occ_after", 32'(bus.occupancy), 32'd0);

      // Job 2: wrap-around, win=4 stride=2 rows=12
      clear_log();
      start_job(4, 2, 12);
      run_job(400, 1'b0, 12, 5);
      check("job2.ndesc", 32'(ndesc), 32'd5);
      check_desc("job2", 0, 0, 3);
      check_desc("job2", 1, 2, 5);
      check_desc("job2", 2, 4, 7);
      check_desc("job2", 3, 6, 1);
      check_desc("job2", 4, 0, 3);
      check("job2.nwr", 32'(nwr), 32'd12);
      for (int i = 0; i < 12; i++)
         check($sformatf("job2.wr_addr%0d", i), 32'(wr_log[i]), 32'(i % 8));
      check("job2.saw_full", 32'(saw_full), 32'd1);
      check("job2.ready_low_when_full", 32'(full_ready_bad), 32'd0);
      check("job2.done", 32'(ndone), 32'd1);

      // Back-to-back write and release at occupancy 3, stride 1
      clear_log();
      start_job(3, 1, 6);
      wcnt = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         bus.win_ready = 1'b1;
         bus.in_valid  = (wcnt < 3);
         #1;
         if (bus.wr_en) wcnt++;
         if (bus.win_valid) break;
      end
      check("b2b.first_desc_start", 32'(bus.win_start_addr), 32'd0);
      @(negedge clk);
      bus.in_valid = 1'b0;
      #1;
      check("b2b.occ_before", 32'(bus.occupancy), 32'd3);
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.win_done = 1'b1;
      #1;
      check("b2b.wr_en", 32'(bus.wr_en), 32'd1);
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.win_done = 1'b0;
      #1;
      check("b2b.occ_after", 32'(bus.occupancy), 32'd3);
      check("b2b.wr_addr", 32'(bus.wr_addr), 32'd4);
      run_job(300, 1'b0, 6, 3);
      check("b2b.ndesc_rest", 32'(ndesc), 32'd3);
      check_desc("b2b", 0, 1, 3);
      check_desc("b2b", 1, 2, 4);
      check_desc("b2b", 2, 3, 5);
      check("b2b.done", 32'(ndone), 32'd1);

      // Leftover rows: win=3 stride=2 rows=6, last row held until DRAIN
      clear_log();
      start_job(3, 2, 6);
      run_job(300, 1'b1, 6, 2);
      check("left.ndesc", 32'(ndesc), 32'd2);
      check_desc("left", 0, 0, 2);
      check_desc("left", 1, 2, 4);
      check("left.nwr", 32'(nwr), 32'd6);
      check("left.busy_at_last_wr", 32'(busy_last), 32'd1);
      check("left.done", 32'(ndone), 32'd1);
      check("left.done_timing", 32'(done_cyc), 32'(last_wr_cyc + 2));

      // Reset in WAIT
      clear_log();
      start_job(3, 1, 5);
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         bus.win_ready = 1'b1;
         bus.in_valid  = 1'b1;
         #1;
         if (bus.win_valid) break;
      end
      @(negedge clk);
      #1;
      check("rstmid.busy_before", 32'(bus.busy), 32'd1);
      #1;
      rst = 1'b1;
      #1;
      check_outputs_zero("rstmid");
      @(negedge clk);
      rst = 1'b0;
      bus.in_valid = 1'b0;
      clear_log();
      start_job(3, 1, 5);
      run_job(300, 1'b0, 5, 3);
      check("rstmid.ndesc", 32'(ndesc), 32'd3);
      check_desc("rstmid", 0, 0, 2);
      check("rstmid.first_wr_addr", 32'(wr_log[0]), 32'd0);
      check("rstmid.done", 32'(ndone), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
